// File: rtl/regfile.sv
// regfile: 32 x 32-bit general-purpose register file.
// One synchronous write port (write-back) and two independent combinational
// read ports (decode). Register 0 is hard-wired to read as zero.
// Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
// Without it, a read of the index being written returns the pre-write value.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] mem [NREGS];

    // A write is committed only for a non-zero index; entry 0 never changes.
    logic wr_commit;
    assign wr_commit = we && (waddr != '0);

    // Storage: cleared asynchronously while rst is low, one write per rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_commit) begin
            mem[waddr] <= wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward write-back data to a port reading the index being written.
    logic byp1;
    logic byp2;
    assign byp1 = wr_commit && (waddr == raddr1);
    assign byp2 = wr_commit && (waddr == raddr2);
`endif

    // Read port 1: reset, disable and r0 force zero; otherwise array (or bypass) data.
    always_comb begin
        rdata1 = '0;
        if (rst && re1 && (raddr1 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (byp1) begin
                rdata1 = wdata;
            end else begin
                rdata1 = mem[raddr1];
            end
`else
            rdata1 = mem[raddr1];
`endif
        end
    end

    // Read port 2: same priority as port 1, fully independent of it.
    always_comb begin
        rdata2 = '0;
        if (rst && re2 && (raddr2 != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (byp2) begin
                rdata2 = wdata;
            end else begin
                rdata2 = mem[raddr2];
            end
`else
            rdata2 = mem[raddr2];
`endif
        end
    end

endmodule
